// File: rtl/hs_sender_array.sv
// rtl/hs_sender_array.sv - per-channel FIFO-fed 4-phase handshake senders
`timescale 1ns/1ps

module hs_sender_array #(
  parameter int NCH     = 2,
  parameter int DW      = 16,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 64,
  localparam int CW     = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic              clkCPU,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [CW-1:0]     wr_ch,
  input  logic [DW-1:0]     wr_data,
  output logic [NCH-1:0]    full,
  input  logic [NCH-1:0]    ack,
  output logic [NCH-1:0]    outsend,
  output logic [NCH*DW-1:0] outdata,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    timeout_err,
  input  logic              err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, REQ, REL} state_t;

  state_t           state   [NCH];
  logic [NCH-1:0]   ack_m;
  logic [NCH-1:0]   ack_s;
  logic [DW-1:0]    mem     [NCH][DEPTH];
  logic [AW-1:0]    wptr    [NCH];
  logic [AW-1:0]    rptr    [NCH];
  logic [AW:0]      count   [NCH];
  logic [AW:0]      cnt_nxt [NCH];
  logic [TW-1:0]    timer   [NCH];
  logic [NCH-1:0]   push;
  logic [NCH-1:0]   pop;

  // An out-of-range wr_ch matches no channel, so the write is dropped.
  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      push[c]    = wr_en && (wr_ch == CW'(c)) && !full[c];
      pop[c]     = (state[c] == IDLE) && (count[c] != '0) && !ack_s[c];
      cnt_nxt[c] = count[c] + {{AW{1'b0}}, push[c]} - {{AW{1'b0}}, pop[c]};
    end
  end

  always_ff @(posedge clkCPU or negedge rst) begin
    if (!rst) begin
      ack_m <= '0;
      ack_s <= '0;
    end else begin
      ack_m <= ack;
      ack_s <= ack_m;
    end
  end

  always_ff @(posedge clkCPU) begin
    for (int c = 0; c < NCH; c++) begin
      if (push[c]) mem[c][wptr[c]] <= wr_data;
    end
  end

  always_ff @(posedge clkCPU or negedge rst) begin
    if (!rst) begin
      for (int c = 0; c < NCH; c++) begin
        state[c] <= IDLE;
        wptr[c]  <= '0;
        rptr[c]  <= '0;
        count[c] <= '0;
        timer[c] <= '0;
      end
      outsend     <= '0;
      outdata     <= '0;
      done        <= '0;
      timeout_err <= '0;
      full        <= '0;
    end else begin
      done <= '0;
      if (err_clr) timeout_err <= '0;
      for (int c = 0; c < NCH; c++) begin
        if (push[c]) wptr[c] <= wptr[c] + AW'(1);
        if (pop[c])  rptr[c] <= rptr[c] + AW'(1);
        count[c] <= cnt_nxt[c];
        full[c]  <= (cnt_nxt[c] == (AW+1)'(DEPTH));
        case (state[c])
          IDLE: begin
            if (pop[c]) begin
              outdata[c*DW +: DW] <= mem[c][rptr[c]];
              outsend[c]          <= 1'b1;
              timer[c]            <= '0;
              state[c]            <= REQ;
            end
          end
          REQ: begin
            if (ack_s[c]) begin
              outsend[c] <= 1'b0;
              done[c]    <= 1'b1;
              state[c]   <= REL;
            end else if (timer[c] == TW'(TIMEOUT - 1)) begin
              // Later assignment overrides err_clr so a same-cycle timeout sticks.
              outsend[c]     <= 1'b0;
              timeout_err[c] <= 1'b1;
              state[c]       <= REL;
            end else begin
              timer[c] <= timer[c] + TW'(1);
            end
          end
          REL: begin
            if (!ack_s[c]) state[c] <= IDLE;
          end
          default: state[c] <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_hs_sender_array.sv
// tb/tb_hs_sender_array.sv - directed scoreboard bench for hs_sender_array
`timescale 1ns/1ps

module tb_hs_sender_array;

  logic        clk = 1'b1;
  logic        pclk0 = 1'b0;
  logic        pclk1 = 1'b0;
  logic        rst;
  logic        wr_en;
  logic        wr_ch;
  logic [15:0] wr_data;
  logic [1:0]  full;
  logic [1:0]  ack;
  logic [1:0]  outsend;
  logic [31:0] outdata;
  logic [1:0]  done;
  logic [1:0]  timeout_err;
  logic        err_clr;

  logic        wr_en3;
  logic [1:0]  wr_ch3;
  logic [15:0] wr_data3;
  logic [2:0]  full3;
  logic [2:0]  ack3;
  logic [2:0]  outsend3;
  logic [47:0] outdata3;
  logic [2:0]  done3;
  logic [2:0]  timeout_err3;
  logic        err_clr3;

  logic [1:0]  ack_auto;
  logic [1:0]  ack_man;
  logic        ack_p0 = 1'b0;
  logic        ack_p1 = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q [2][$];
  int done_cnt [2];
  int tout_cnt [2];
  int hi_len   [2];
  int last_len [2];
  logic [1:0]  prev_os;
  logic [1:0]  prev_done;
  logic [15:0] prev_od [2];

  always #10 clk = ~clk;
  always #17 pclk0 = ~pclk0;
  always #8  pclk1 = ~pclk1;

  // Peripherals echo the request back (4-phase) on their own clocks.
  always @(posedge pclk0) ack_p0 <= outsend[0];
  always @(posedge pclk1) ack_p1 <= outsend[1];
  assign ack = {ack_auto[1] ? ack_p1 : ack_man[1], ack_auto[0] ? ack_p0 : ack_man[0]};

  hs_sender_array #(.NCH(2), .DW(16), .DEPTH(4), .TIMEOUT(64)) u_dut (
    .clkCPU(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_data(wr_data),
    .full(full), .ack(ack), .outsend(outsend), .outdata(outdata), .done(done),
    .timeout_err(timeout_err), .err_clr(err_clr)
  );

  hs_sender_array #(.NCH(3), .DW(16), .DEPTH(4), .TIMEOUT(8)) u_dut3 (
    .clkCPU(clk), .rst(rst), .wr_en(wr_en3), .wr_ch(wr_ch3), .wr_data(wr_data3),
    .full(full3), .ack(ack3), .outsend(outsend3), .outdata(outdata3), .done(done3),
    .timeout_err(timeout_err3), .err_clr(err_clr3)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int c, input logic [15:0] d, input bit accept);
    wr_en   = 1'b1;
    wr_ch   = 1'(c);
    wr_data = d;
    if (accept) exp_q[c].push_back(d);
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic wait_drain(input int c, input int maxcyc);
    int n = 0;
    while ((exp_q[c].size() != 0 || outsend[c] || ack[c]) && n < maxcyc) begin
      @(negedge clk);
      n++;
    end
    chk("drain_in_time", 64'(n < maxcyc), 64'(1));
    repeat (4) @(negedge clk);
  endtask

  // Output monitor: scoreboard compare on done, data stability, timeout detection.
  initial begin
    logic [15:0] e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        prev_os   = '0;
        prev_done = '0;
        hi_len[0] = 0;
        hi_len[1] = 0;
      end else begin
        for (int c = 0; c < 2; c++) begin
          if (outsend[c]) hi_len[c]++;
          if (outsend[c] && prev_os[c])
            chk("data_stable", 64'(outdata[c*16 +: 16]), 64'(prev_od[c]));
          if (done[c]) begin
            chk("done_single", 64'(prev_done[c]), 64'(0));
            done_cnt[c]++;
            chk("done_expected", 64'(exp_q[c].size() > 0), 64'(1));
            if (exp_q[c].size() > 0) begin
              e = exp_q[c].pop_front();
              chk("done_data", 64'(outdata[c*16 +: 16]), 64'(e));
            end
          end
          if (prev_os[c] && !outsend[c]) begin
            last_len[c] = hi_len[c];
            hi_len[c]   = 0;
            if (!done[c]) begin
              tout_cnt[c]++;
              if (exp_q[c].size() > 0) void'(exp_q[c].pop_front());
            end
          end
          prev_od[c] = outdata[c*16 +: 16];
        end
        prev_os   = outsend;
        prev_done = done;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, d1, n;
    rst = 1'b0; wr_en = 1'b0; wr_ch = 1'b0; wr_data = '0; err_clr = 1'b0;
    wr_en3 = 1'b0; wr_ch3 = '0; wr_data3 = '0; ack3 = '0; err_clr3 = 1'b0;
    ack_auto = '0; ack_man = '0;
    done_cnt[0] = 0; done_cnt[1] = 0; tout_cnt[0] = 0; tout_cnt[1] = 0;
    last_len[0] = 0; last_len[1] = 0;

    // Reset state
    #40;
    chk("rst_outsend", 64'(outsend), 64'(0));
    chk("rst_outdata", 64'(outdata), 64'(0));
    chk("rst_done", 64'(done), 64'(0));
    chk("rst_terr", 64'(timeout_err), 64'(0));
    chk("rst_full", 64'(full), 64'(0));
    chk("rst3_outs", 64'({outsend3, done3, timeout_err3, full3}), 64'(0));
    #10 rst = 1'b1;
    repeat (2) @(negedge clk);

    // Single word with manual ack: latency and release timing
    push(0, 16'hA5A5, 1'b1);
    chk("lat_edge_k", 64'(outsend[0]), 64'(0));
    @(negedge clk);
    chk("lat_edge_k1", 64'(outsend[0]), 64'(1));
    chk("load_data", 64'(outdata[15:0]), 64'(16'hA5A5));
    repeat (2) @(negedge clk);
    ack_man[0] = 1'b1;
    d0 = done_cnt[0];
    @(negedge clk); chk("rel_e1", 64'(outsend[0]), 64'(1));
    @(negedge clk); chk("rel_e2", 64'(outsend[0]), 64'(1));
    @(negedge clk); chk("rel_e3", 64'(outsend[0]), 64'(0));
    chk("done_pulse", 64'(done[0]), 64'(1));
    @(negedge clk); chk("done_off", 64'(done[0]), 64'(0));
    @(negedge clk); chk("done_count1", 64'(done_cnt[0] - d0), 64'(1));
    ack_man[0] = 1'b0;
    repeat (4) @(negedge clk);

    // Fill ch1 while ack held high (blocks pop), 5th word dropped
    ack_man[1] = 1'b1;
    repeat (3) @(negedge clk);
    d1 = done_cnt[1];
    for (int i = 1; i <= 4; i++) push(1, 16'(i), 1'b1);
    chk("full_after4", 64'(full[1]), 64'(1));
    chk("full_ch0_clear", 64'(full[0]), 64'(0));
    push(1, 16'd5, 1'b0);
    chk("full_after5", 64'(full[1]), 64'(1));
    chk("blocked_send", 64'(outsend[1]), 64'(0));
    ack_man[1]  = 1'b0;
    ack_auto[1] = 1'b1;
    wait_drain(1, 400);
    chk("ch1_four_sent", 64'(done_cnt[1] - d1), 64'(4));
    chk("ch1_full_clear", 64'(full[1]), 64'(0));

    // Timeout on ch0, next word then delivered, err_clr
    d0 = done_cnt[0];
    push(0, 16'h1111, 1'b1);
    push(0, 16'h2222, 1'b1);
    n = 0;
    while (tout_cnt[0] == 0 && n < 200) begin @(negedge clk); n++; end
    chk("tout_seen", 64'(tout_cnt[0]), 64'(1));
    chk("tout_len", 64'(last_len[0]), 64'(64));
    chk("tout_err0", 64'(timeout_err[0]), 64'(1));
    chk("tout_err1", 64'(timeout_err[1]), 64'(0));
    chk("tout_nodone", 64'(done_cnt[0] - d0), 64'(0));
    ack_auto[0] = 1'b1;
    wait_drain(0, 300);
    chk("tout_next_word", 64'(done_cnt[0] - d0), 64'(1));
    chk("tout_err_sticky", 64'(timeout_err[0]), 64'(1));
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    chk("err_clr", 64'(timeout_err), 64'(0));

    // Two peripherals on unrelated clocks, 10 words each
    d0 = done_cnt[0]; d1 = done_cnt[1];
    ack_auto = 2'b11;
    for (int i = 0; i < 10; i++) begin
      for (int c = 0; c < 2; c++) begin
        n = 0;
        while (exp_q[c].size() >= 4 && n < 2000) begin @(negedge clk); n++; end
        push(c, 16'((c << 12) | (i * 7 + 3)), 1'b1);
      end
    end
    wait_drain(0, 2000);
    wait_drain(1, 2000);
    chk("multi_done0", 64'(done_cnt[0] - d0), 64'(10));
    chk("multi_done1", 64'(done_cnt[1] - d1), 64'(10));
    chk("multi_no_tout", 64'(timeout_err), 64'(0));

    // Reset mid-handshake with words queued
    ack_auto = '0; ack_man = '0;
    repeat (4) @(negedge clk);
    d1 = done_cnt[1];
    push(1, 16'h0B01, 1'b1);
    push(1, 16'h0B02, 1'b1);
    push(1, 16'h0B03, 1'b1);
    @(negedge clk);
    chk("mid_outsend", 64'(outsend[1]), 64'(1));
    #5 rst = 1'b0;
    #1;
    chk("async_outsend", 64'(outsend), 64'(0));
    chk("async_outdata", 64'(outdata), 64'(0));
    chk("async_full", 64'(full), 64'(0));
    exp_q[0].delete();
    exp_q[1].delete();
    @(negedge clk);
    rst = 1'b1;
    repeat (10) @(negedge clk);
    chk("post_rst_send", 64'(outsend), 64'(0));
    chk("post_rst_full", 64'(full), 64'(0));
    chk("post_rst_done", 64'(done_cnt[1] - d1), 64'(0));

    // NCH=3 instance: out-of-range channel ignored, valid channel works
    wr_en3 = 1'b1; wr_ch3 = 2'd3; wr_data3 = 16'hDEAD;
    repeat (6) @(negedge clk);
    wr_en3 = 1'b0;
    repeat (2) @(negedge clk);
    chk("badch_outsend", 64'(outsend3), 64'(0));
    chk("badch_full", 64'(full3), 64'(0));
    wr_en3 = 1'b1; wr_ch3 = 2'd2; wr_data3 = 16'hC3C3;
    @(negedge clk);
    wr_en3 = 1'b0;
    chk("ch2_lat_k", 64'(outsend3), 64'(0));
    @(negedge clk);
    chk("ch2_lat_k1", 64'(outsend3), 64'(3'b100));
    chk("ch2_data", 64'(outdata3[47:32]), 64'(16'hC3C3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
